// File: rtl/hba_pkg.sv
// HBA arbiter shared types and constants.
// State encodings, default sizing and the owner-width helper.
package hba_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } hba_state_e;

  localparam int HBA_NUM_MASTERS_DEFAULT = 4;
  localparam int HBA_TIMEOUT_DEFAULT     = 255;

  function automatic int hba_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int HBA_OWNER_WIDTH_DEFAULT =
    hba_idx_width(HBA_NUM_MASTERS_DEFAULT);

endpackage

// File: rtl/hba_rr_pick.sv
// Round-robin winner pick over a pending vector.
// Scans upward from last+1 and wraps to index 0.
module hba_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         valid
);

  logic [N-1:0] above;
  logic [N-1:0] hi;

  // Mask of indices strictly after the last owner
  always_comb begin
    above = '0;
    for (int i = 0; i < N; i++) begin
      above[i] = (W'(i) > last);
    end
  end

  assign hi = pending & above;

  // Lowest pending above last wins, else lowest pending overall
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winner = W'(i);
        valid  = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (hi[i]) begin
        winner = W'(i);
      end
    end
  end

endmodule

// File: rtl/hba_arbiter.sv
// HBA bus arbiter: latched request pulses, round-robin grant,
// grant held until xferack, watchdog-forced release.
module hba_arbiter
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS    = HBA_NUM_MASTERS_DEFAULT,
  parameter int OWNER_WIDTH    = HBA_OWNER_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = HBA_TIMEOUT_DEFAULT,
  parameter int TIMER_WIDTH    = 8
) (
  input  logic                   hba_clk,
  input  logic                   hba_reset,
  input  logic [NUM_MASTERS-1:0] hba_mrequest,
  input  logic                   hba_xferack,
  output logic [NUM_MASTERS-1:0] hba_mgrant,
  output logic [OWNER_WIDTH-1:0] arb_owner,
  output logic                   arb_busy,
  output logic                   arb_timeout
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_WIDTH-1:0] TO_LAST =
    TIMER_WIDTH'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [OWNER_WIDTH-1:0] OWNER_RST =
    OWNER_WIDTH'(NUM_MASTERS - 1);

  hba_state_e             state, state_n;
  logic [NUM_MASTERS-1:0] pending, pending_n;
  logic [NUM_MASTERS-1:0] grant_n, clr;
  logic [OWNER_WIDTH-1:0] owner_n, pick_idx;
  logic [TIMER_WIDTH-1:0] timer, timer_n;
  logic                   timeout_n, pick_valid;

  hba_rr_pick #(
    .N (NUM_MASTERS),
    .W (OWNER_WIDTH)
  ) u_pick (
    .pending (pending),
    .last    (arb_owner),
    .winner  (pick_idx),
    .valid   (pick_valid)
  );

  // A new pulse outranks the clear of the finishing owner
  assign pending_n = (pending & ~clr) | hba_mrequest;

  // Next-state, grant, owner and watchdog decisions
  always_comb begin
    state_n   = state;
    grant_n   = hba_mgrant;
    owner_n   = arb_owner;
    timer_n   = timer;
    timeout_n = 1'b0;
    clr       = '0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_n = NUM_MASTERS'(1) << pick_idx;
          owner_n = pick_idx;
          timer_n = '0;
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        timer_n = timer + 1'b1;
        if (hba_xferack) begin
          grant_n = '0;
          clr     = hba_mgrant;
          state_n = ST_RELEASE;
        end else if (TO_EN && timer == TO_LAST) begin
          grant_n   = '0;
          clr       = hba_mgrant;
          timeout_n = 1'b1;
          state_n   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        grant_n = '0;
        state_n = ST_IDLE;
      end
      default: begin
        grant_n = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // Arbiter state and registered outputs
  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      state       <= ST_IDLE;
      pending     <= '0;
      hba_mgrant  <= '0;
      arb_owner   <= OWNER_RST;
      arb_busy    <= 1'b0;
      arb_timeout <= 1'b0;
      timer       <= '0;
    end else begin
      state       <= state_n;
      pending     <= pending_n;
      hba_mgrant  <= grant_n;
      arb_owner   <= owner_n;
      arb_busy    <= (state_n != ST_IDLE);
      arb_timeout <= timeout_n;
      timer       <= timer_n;
    end
  end

endmodule

// File: doc/hba_arbiter.md
Name: hba_arbiter

Overview:
- Shares the single HBA bus between up to NUM_MASTERS hba_master instances using round-robin arbitration.
- Each master pulses its hba_mrequest for one cycle only. The arbiter latches that pulse as a pending request, grants one master at a time, and holds the grant until the slave returns hba_xferack.
- A per-transfer watchdog frees the bus if a slave never acknowledges.
- Sits between the master-side hba_mrequest/hba_mgrant wires and the bus-wide hba_xferack.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (1..16)
- OWNER_WIDTH, 2, width of owner index; set to clog2(NUM_MASTERS), minimum 1
- TIMEOUT_CYCLES, 255, maximum cycles in GRANT before a forced release; 0 disables the watchdog
- TIMER_WIDTH, 8, width of the watchdog counter; must hold TIMEOUT_CYCLES

Ports:
- hba_clk  in  1  bus clock
- hba_reset  in  1  asynchronous, active-high reset
- hba_mrequest  in  NUM_MASTERS  one-cycle request pulse per master
- hba_xferack  in  1  OR of slave transfer-complete acks
- hba_mgrant  out  NUM_MASTERS  one-hot grant, registered
- arb_owner  out  OWNER_WIDTH  index of current/last granted master
- arb_busy  out  1  high while in GRANT or RELEASE
- arb_timeout  out  1  one-cycle pulse when the watchdog forces a release

Behaviour:
- Reset (async assert, release sync to hba_clk):
  - state=IDLE, pending=0, hba_mgrant=0, arb_owner=NUM_MASTERS-1, arb_busy=0, arb_timeout=0, timer=0.
  - Reset mid-transfer drops the grant immediately and discards all pending requests.
- pending[i]:
  - Set on any edge where hba_mrequest[i]=1.
  - Cleared when master i's grant ends (ack or timeout).
  - Set has priority over clear in the same cycle.
- States:
  - IDLE: if pending!=0, pick the winner by scanning from (arb_owner+1) mod NUM_MASTERS upward with wrap. Register hba_mgrant=onehot(winner), arb_owner=winner, timer=0, go to GRANT. If pending=0, stay in IDLE.
  - GRANT: hba_mgrant held constant; timer increments each cycle.
    - If hba_xferack=1: hba_mgrant<=0, clear pending[owner], go to RELEASE.
    - Else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: hba_mgrant<=0, clear pending[owner], arb_timeout<=1 for one cycle, go to RELEASE.
    - hba_xferack wins if it coincides with the timeout.
  - RELEASE: exactly one dead cycle so the owner drops hba_select_master before the next grant; go to IDLE.
  - Illegal state encoding: go to IDLE with hba_mgrant=0.
- Latency: request pulse sampled at edge k, then hba_mgrant high after edge k+1 (bus idle). Minimum spacing between consecutive grants is 3 cycles (GRANT ack edge, RELEASE, IDLE pick).
- hba_xferack in IDLE or RELEASE is ignored.
- Simultaneous requests: the lowest index at or above (arb_owner+1), with wrap, wins; the others stay pending.
- A repeat pulse from a master that is already pending is absorbed; no double grant.
- arb_busy = (state != IDLE), registered.
- hba_mgrant is one-hot or zero at all times; never more than one bit set.

Decomposition:
- Shared package hba_pkg holds:
  - state encodings IDLE/GRANT/RELEASE
  - default TIMEOUT_CYCLES
  - helper constant for the clog2 width
- One natural sub-module: hba_rr_pick, combinational, inputs pending and last owner, outputs winner index and valid. It is reusable by future HBA arbiters.

Test Plan:
- Single request: mrequest=0001 pulse at cycle 2 → mgrant=0001 from cycle 3; xferack at cycle 6 → mgrant=0000 at cycle 7, arb_busy falls at cycle 8.
- Fairness: mrequest=1111 pulse at once, ack each grant after 2 cycles → grant order 0,1,2,3. Repeat with owner=1 → order 2,3,0,1.
- Wrap and absorb: NUM_MASTERS=4, owner=3, pulses on masters 3 and 0 → master 0 granted first. Master 0 re-pulses while pending → exactly one grant.
- Timeout: TIMEOUT_CYCLES=8, grant master 2, no ack → mgrant drops after 8 GRANT cycles, arb_timeout pulses once, pending[2]=0, master 3 (pending) granted after RELEASE.
- Ack/timeout collision: xferack arrives on the timeout cycle → arb_timeout stays 0.
- Async reset mid-GRANT, asserted between clock edges → mgrant=0 immediately. After release with no new requests, mgrant stays 0 and owner=NUM_MASTERS-1.
